// File: rtl/seq_multiplier_core.sv
// Shift-add multiplier with start/busy/done handshake; 2*WIDTH-bit registered product.
// Latency: WIDTH edges from accept to done, or msb_index(B)+1 (min 1) with EARLY_EXIT=1.
// Backpressure: start accepted only when ready; ignored while busy. Optional macro MULT_SIGNED_EN.
module seq_multiplier_core #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 busy,
    output logic                 ready,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [2*WIDTH-1:0] r_a_sh;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [2*WIDTH-1:0] w_acc_nx;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [CW-1:0]      r_cnt;
    logic               w_last;
    logic               w_accept;

`ifdef MULT_SIGNED_EN
    // Magnitude of the most negative operand is 2^(WIDTH-1), which still fits
    // the WIDTH-bit unsigned magnitude register, so the product stays exact.
    logic r_neg;

    assign w_a_mag  = A_in[WIDTH-1] ? (~A_in + 1'b1) : A_in;
    assign w_b_mag  = B_in[WIDTH-1] ? (~B_in + 1'b1) : B_in;
    assign w_result = r_neg ? (~w_acc_nx + 1'b1) : w_acc_nx;

    // Result sign captured with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= A_in[WIDTH-1] ^ B_in[WIDTH-1];
        end
    end
`else
    assign w_a_mag  = A_in;
    assign w_b_mag  = B_in;
    assign w_result = w_acc_nx;
`endif

    // Partial product for this step and the termination condition; early exit
    // fires once no set multiplier bits remain after the current one.
    assign w_acc_nx = r_acc + (r_b_sh[0] ? r_a_sh : '0);
    assign w_last   = (r_cnt == CW'(WIDTH - 1)) ||
                      (EARLY_EXIT && ((r_b_sh >> 1) == '0));
    assign w_accept = (r_state != S_BUSY) && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and handshake outputs; DONE lasts one cycle unless restarted
    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) w_state_nx = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = start ? S_BUSY : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
        ready = ~busy;
    end

    // Operand latch on accept, one shift-add step per busy cycle, result write on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a_sh <= {{WIDTH{1'b0}}, w_a_mag};
            r_b_sh <= w_b_mag;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc  <= w_acc_nx;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) r_product <= w_result;
        end
    end

    assign product_out = r_product;

endmodule
